// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8002_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/fetch_insn_buf.sv
// rtl/fetch_insn_buf.sv - output slot plus one-entry skid holding fetched instructions for decode
module fetch_insn_buf (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_insn,
  input  logic [31:0] push_pc,
  input  logic        flush,
  input  logic        stall,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        valid,
  output logic        full
);

  logic [31:0] skid_insn;
  logic [31:0] skid_pc;
  logic        skid_valid;
  logic        slot_free;

  assign slot_free = !valid || !stall;
  assign full      = skid_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      insn       <= '0;
      pc         <= '0;
      valid      <= 1'b0;
      skid_insn  <= '0;
      skid_pc    <= '0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      valid      <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid && slot_free) begin
      // Older skid entry advances first; a same-edge arrival refills the skid.
      insn       <= skid_insn;
      pc         <= skid_pc;
      valid      <= 1'b1;
      skid_valid <= push;
      if (push) begin
        skid_insn <= push_insn;
        skid_pc   <= push_pc;
      end
    end else if (slot_free) begin
      valid <= push;
      if (push) begin
        insn <= push_insn;
        pc   <= push_pc;
      end
    end else if (push) begin
      skid_insn  <= push_insn;
      skid_pc    <= push_pc;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch PC, one-at-a-time imem requests and redirect handling; FETCH_ALIGN_CHECK_EN enables the misaligned-target fault
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] insn_out,
  output logic [31:0] pc_out,
  output logic        insn_valid,
  output logic        fetch_fault
);

  fetch_state_t state, state_next;
  logic [31:0]  fetch_pc, fetch_pc_next;
  logic [31:0]  redir_pc, redir_pc_next;
  logic         take;
  logic [31:0]  tgt;
  logic         push;
  logic         buf_full;

  assign push     = (state == S_FETCH) && imem_rvalid && !redirect_valid;
  assign imem_req = (state == S_FETCH) || (state == S_DRAIN);

`ifdef FETCH_ALIGN_CHECK_EN
  assign imem_addr   = fetch_pc;
  assign fetch_fault = (state == S_FAULT);
`else
  assign imem_addr   = {fetch_pc[31:2], 2'b00};
  assign fetch_fault = 1'b0;
`endif

  fetch_insn_buf u_buf (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_insn (imem_rdata),
    .push_pc   (fetch_pc),
    .flush     (redirect_valid),
    .stall     (stall_in),
    .insn      (insn_out),
    .pc        (pc_out),
    .valid     (insn_valid),
    .full      (buf_full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      redir_pc <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      redir_pc <= redir_pc_next;
    end
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    redir_pc_next = redir_pc;
    take          = 1'b0;
    tgt           = redirect_pc;
    case (state)
      S_FETCH: begin
        if (redirect_valid) begin
          if (imem_rvalid) begin
            take = 1'b1;
          end else begin
            redir_pc_next = redirect_pc;
            state_next    = S_DRAIN;
          end
        end else if (imem_rvalid) begin
          fetch_pc_next = fetch_pc + PC_INCR;
          if (buf_full || (insn_valid && stall_in)) state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (redirect_valid) take = 1'b1;
        else if (!stall_in) state_next = S_FETCH;
      end
      S_DRAIN: begin
        // A redirect landing on the drained response completes the drain at once.
        if (redirect_valid) begin
          if (imem_rvalid) take = 1'b1;
          else redir_pc_next = redirect_pc;
        end else if (imem_rvalid) begin
          take = 1'b1;
          tgt  = redir_pc;
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_FAULT: begin
        if (redirect_valid) take = 1'b1;
      end
`endif
      default: state_next = S_FETCH;
    endcase
    if (take) begin
      fetch_pc_next = tgt;
`ifdef FETCH_ALIGN_CHECK_EN
      state_next = (tgt[1:0] != 2'b00) ? S_FAULT : S_FETCH;
`else
      state_next = S_FETCH;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit with a queue-based reference model
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  localparam logic [31:0] RST_PC = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] insn_out;
  logic [31:0] pc_out;
  logic        insn_valid;
  logic        fetch_fault;

  int errors = 0;
  int checks = 0;

  ent_t        q[$];
  logic        pending = 1'b0;
  logic        stale = 1'b0;
  logic        fault = 1'b0;
  logic        new_req = 1'b0;
  int          cnt = 0;
  int          lat = 1;
  logic [31:0] exp_addr = RST_PC;
  logic [31:0] paddr = '0;
  logic [31:0] mem_addr = '0;
  logic        did;
  logic        hit;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .insn_out       (insn_out),
    .pc_out         (pc_out),
    .insn_valid     (insn_valid),
    .fetch_fault    (fetch_fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] amask(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + 32'h0F0F_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs, advance the model to the next edge.
  task automatic step(input logic st, input int rmode, input logic [31:0] tgt, output logic dd);
    logic resp;
    resp    = 1'b0;
    new_req = 1'b0;
    chk("imem_req", imem_req, pending || (q.size() < 2 && !fault));
    chk("insn_valid", insn_valid, q.size() != 0);
    chk("fetch_fault", fetch_fault, fault && !pending);
    if (q.size() != 0) begin
      chk("pc_out", pc_out, q[0].pc);
      chk("insn_out", insn_out, q[0].insn);
    end
    if (pending) begin
      chk("imem_addr_hold", imem_addr, mem_addr);
      cnt++;
      if (cnt >= lat) resp = 1'b1;
    end else if (imem_req) begin
      chk("imem_addr", imem_addr, amask(exp_addr));
      pending  = 1'b1;
      stale    = 1'b0;
      cnt      = 0;
      paddr    = exp_addr;
      mem_addr = imem_addr;
      new_req  = 1'b1;
    end
    dd             = (rmode == 1) || (rmode == 2 && resp);
    imem_rvalid    = resp;
    imem_rdata     = resp ? mem_word(amask(mem_addr)) : $urandom;
    stall_in       = st;
    redirect_valid = dd;
    redirect_pc    = dd ? tgt : $urandom;
    if (dd) begin
      q.delete();
      exp_addr = tgt;
`ifdef FETCH_ALIGN_CHECK_EN
      fault = (tgt[1:0] != 2'b00);
`endif
      if (pending && !resp) stale = 1'b1;
    end else begin
      if (q.size() != 0 && !st) void'(q.pop_front());
      if (resp && !stale) begin
        q.push_back('{pc: paddr, insn: mem_word(amask(paddr))});
        exp_addr = paddr + 32'd4;
      end
    end
    if (resp) pending = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b1;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b0;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    q.delete();
    pending  = 1'b0;
    stale    = 1'b0;
    fault    = 1'b0;
    exp_addr = RST_PC;
    chk("rst_insn_valid", insn_valid, 0);
    chk("rst_insn_out", insn_out, 0);
    chk("rst_pc_out", pc_out, 0);
    chk("rst_fetch_fault", fetch_fault, 0);
    chk("rst_imem_req", imem_req, 1);
    chk("rst_imem_addr", imem_addr, RST_PC);
  endtask

  initial begin
    logic        st;
    logic [31:0] t;
    @(negedge clock);
    do_reset(2);

    lat = 1;
    repeat (12) step(1'b0, 0, '0, did);
    repeat (10) step(1'b1, 0, '0, did);
    chk("full_no_req", imem_req, 0);
    chk("full_valid", insn_valid, 1);
    repeat (8) step(1'b0, 0, '0, did);

    lat = 3;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 0, '0, did);
      if (new_req) break;
    end
    chk("p4_req_seen", new_req, 1);
    step(1'b0, 1, 32'h0000_1000, did);
    repeat (12) step(1'b0, 0, '0, did);

    lat = 1;
    repeat (3) step(1'b0, 0, '0, did);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step(1'b1, (q.size() == 1) ? 2 : 0, 32'h0000_3000, did);
      hit = did;
    end
    chk("p5_hit", hit, 1);
    chk("p5_empty", insn_valid, 0);
    chk("p5_req", imem_req, 1);
    chk("p5_addr", imem_addr, 32'h0000_3000);
    repeat (8) step(1'b0, 0, '0, did);

    step(1'b0, 1, 32'hFFFF_FFFC, did);
    repeat (10) step(1'b0, 0, '0, did);

    step(1'b0, 1, 32'h0000_1002, did);
    repeat (8) step(1'b0, 0, '0, did);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("p7_fault", fetch_fault, 1);
    chk("p7_noreq", imem_req, 0);
`endif
    step(1'b0, 1, 32'h0000_2000, did);
    repeat (8) step(1'b0, 0, '0, did);

    for (int l = 1; l <= 4; l++) begin
      lat = l;
      for (int i = 0; i < 300; i++) begin
        st = ($urandom_range(0, 99) < 35);
        t  = $urandom;
        if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
        step(st, ($urandom_range(0, 99) < 4) ? 1 : 0, t, did);
      end
    end

    lat = 2;
    step(1'b0, 1, 32'h0000_4000, did);
    repeat (3) step(1'b0, 0, '0, did);
    do_reset(1);
    repeat (20) step(1'b0, 0, '0, did);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
